// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg
//   Shared constants for the instruction fetch stage: default instruction and
//   address widths, the reset PC, the fetch alignment and the default depth of
//   the fetch buffers.
package inst_fetch_pkg;

   localparam int          INST_W          = 32;
   localparam int          REG_W           = 32;
   localparam logic [31:0] DEF_RESET_PC    = 32'h0000_0000;
   localparam int          IMEM_ALIGN_BITS = 2;
   localparam int          DEF_FIFO_DEPTH  = 2;

endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if
//   Bundles the fetch stage's buses:
//     imem_req_*     request channel to instruction memory (valid/ready)
//     imem_rsp_*     in-order response channel, never back-pressured
//     redirect_*     flush/restart from branch and jump resolution
//     inst_*         instruction plus PC to decode (valid/ready)
//   master: the fetch stage.  slave: memory/decode/branch side.
//   IW/RW must match the fetch stage's INST_WIDTH/REG_WIDTH.
interface inst_fetch_if
   import inst_fetch_pkg::*;
#(
   parameter int IW = INST_W,
   parameter int RW = REG_W
) ();

   logic          imem_req_valid;
   logic          imem_req_ready;
   logic [RW-1:0] imem_req_addr;
   logic          imem_rsp_valid;
   logic [IW-1:0] imem_rsp_data;
   logic          redirect_valid;
   logic [RW-1:0] redirect_pc;
   logic          inst_valid;
   logic          inst_ready;
   logic [IW-1:0] inst_out;
   logic [RW-1:0] inst_pc;

   modport master (
      output imem_req_valid, imem_req_addr, inst_valid, inst_out, inst_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
             redirect_valid, redirect_pc, inst_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, inst_valid, inst_out, inst_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
             redirect_valid, redirect_pc, inst_ready
   );

endinterface

// File: rtl/inst_fetch_sync_fifo.sv
// inst_fetch_sync_fifo
//   Small synchronous FIFO with flush, registered storage and head-of-queue
//   output (o_data is the oldest entry, valid while !o_empty).
//   Ports: clk, rst_n (async active-low), i_push/i_data, i_pop, i_flush,
//          o_data, o_full, o_empty, o_count.
//   Push when full and pop when empty are ignored; flush wins over both.
module inst_fetch_sync_fifo
   import inst_fetch_pkg::*;
#(
   parameter int WIDTH = REG_W,
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_push,
   input  logic [WIDTH-1:0]      i_data,
   input  logic                  i_pop,
   input  logic                  i_flush,
   output logic [WIDTH-1:0]      o_data,
   output logic                  o_full,
   output logic                  o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd_ptr];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   // Storage is cleared on reset so the head output reads zero during reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_push && !i_flush) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch
//   Instruction fetch stage. Owns the PC, issues word-aligned requests to
//   instruction memory, buffers in-order responses with their PCs and hands
//   them to decode. A redirect flushes everything buffered and discards all
//   responses still in flight.
//   Ports: clk, rst_n (async active-low), bus (inst_fetch_if.master).
//   Request issue is credit based: requests in flight plus buffered
//   instructions never exceed FIFO_DEPTH, so a response always finds a slot.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int                   INST_WIDTH = INST_W,
   parameter int                   REG_WIDTH  = REG_W,
   parameter logic [REG_WIDTH-1:0] RESET_PC   = DEF_RESET_PC,
   parameter int                   FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input logic           clk,
   input logic           rst_n,
   inst_fetch_if.master  bus
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int SUM_W = CNT_W + 1;
   localparam int BUF_W = INST_WIDTH + REG_WIDTH;

   logic [REG_WIDTH-1:0] r_pc;
   logic [CNT_W-1:0]     r_outstanding;
   logic [CNT_W-1:0]     r_drop;

   logic                 w_credit_ok;
   logic                 w_accept;
   logic                 w_rsp_keep;
   logic [REG_WIDTH-1:0] w_tag_pc;
   logic [BUF_W-1:0]     w_buf_data;
   logic                 w_buf_empty;
   logic [CNT_W-1:0]     w_buf_count;
   logic                 w_unused_tag_full;
   logic                 w_unused_tag_empty;
   logic [CNT_W-1:0]     w_unused_tag_count;
   logic                 w_unused_buf_full;

   assign w_credit_ok = (SUM_W'(r_outstanding) + SUM_W'(w_buf_count)) < SUM_W'(FIFO_DEPTH);

   // rst_n gates the request so nothing is presented while reset is held.
   assign bus.imem_req_valid = rst_n && !bus.redirect_valid && w_credit_ok;
   assign bus.imem_req_addr  = {r_pc[REG_WIDTH-1:IMEM_ALIGN_BITS], {IMEM_ALIGN_BITS{1'b0}}};
   assign w_accept           = bus.imem_req_valid && bus.imem_req_ready;

   // Responses arriving while drop is nonzero belong to a flushed stream.
   assign w_rsp_keep = bus.imem_rsp_valid && (r_drop == '0);

   assign bus.inst_valid = !w_buf_empty;
   assign bus.inst_out   = w_buf_data[BUF_W-1:REG_WIDTH];
   assign bus.inst_pc    = w_buf_data[REG_WIDTH-1:0];

   // PCs of undropped in-flight requests, in issue order.
   inst_fetch_sync_fifo #(.WIDTH(REG_WIDTH), .DEPTH(FIFO_DEPTH)) u_tag_q (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_accept),
      .i_data  (bus.imem_req_addr),
      .i_pop   (w_rsp_keep),
      .i_flush (bus.redirect_valid),
      .o_data  (w_tag_pc),
      .o_full  (w_unused_tag_full),
      .o_empty (w_unused_tag_empty),
      .o_count (w_unused_tag_count)
   );

   // Returned instructions with their PCs, waiting for decode.
   inst_fetch_sync_fifo #(.WIDTH(BUF_W), .DEPTH(FIFO_DEPTH)) u_inst_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_rsp_keep && !bus.redirect_valid),
      .i_data  ({bus.imem_rsp_data, w_tag_pc}),
      .i_pop   (bus.inst_valid && bus.inst_ready),
      .i_flush (bus.redirect_valid),
      .o_data  (w_buf_data),
      .o_full  (w_unused_buf_full),
      .o_empty (w_buf_empty),
      .o_count (w_buf_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc          <= RESET_PC;
         r_outstanding <= '0;
         r_drop        <= '0;
      end else if (bus.redirect_valid) begin
         // Everything still in flight after this cycle is stale: a response
         // landing now retires one, the rest must be dropped on arrival.
         r_pc          <= {bus.redirect_pc[REG_WIDTH-1:IMEM_ALIGN_BITS], {IMEM_ALIGN_BITS{1'b0}}};
         r_drop        <= r_outstanding - CNT_W'(bus.imem_rsp_valid);
         r_outstanding <= r_outstanding - CNT_W'(bus.imem_rsp_valid);
      end else begin
         if (w_accept) r_pc <= r_pc + REG_WIDTH'(4);
         case ({w_accept, bus.imem_rsp_valid})
            2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
            2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
            default: ;
         endcase
         if (bus.imem_rsp_valid && (r_drop != '0)) r_drop <= r_drop - CNT_W'(1);
      end
   end

endmodule
